// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle hysteresis, quiesce
// handshake with the downstream unit, and a glitch-free latch-based clock gate.
module clock_gate_ctrl #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned CNT_W  = 8,
   parameter bit          BYPASS = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             test_en_i,
   input  logic [CNT_W-1:0] idle_cycles_i,
   input  logic [NCH-1:0]   allow_gate_i,
   input  logic [NCH-1:0]   busy_i,
   input  logic [NCH-1:0]   quiesce_ack_i,
   output logic [NCH-1:0]   quiesce_req_o,
   output logic [NCH-1:0]   en_o,
   output logic [NCH-1:0]   clk_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_ON      = 2'd0,
      ST_COUNT   = 2'd1,
      ST_QUIESCE = 2'd2,
      ST_OFF     = 2'd3
   } state_t;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             en;
      logic             req;
      logic             en_nxt;
      logic             req_nxt;
      logic             wake;

      assign wake = busy_i[i] | ~allow_gate_i[i] | test_en_i;

      // State, idle counter and registered outputs
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state <= ST_ON;
            cnt   <= '0;
            en    <= 1'b1;
            req   <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            en    <= en_nxt;
            req   <= req_nxt;
         end
      end

      // Next state; any wake cause wins over counting and over a pending ack
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         unique case (state)
            ST_ON: begin
               if (wake) begin
                  cnt_nxt = '0;
               end else if (idle_cycles_i == '0) begin
                  state_nxt = ST_QUIESCE;
               end else begin
                  state_nxt = ST_COUNT;
                  cnt_nxt   = CNT_W'(1);
               end
            end
            ST_COUNT: begin
               if (wake) begin
                  state_nxt = ST_ON;
                  cnt_nxt   = '0;
               end else if (cnt >= idle_cycles_i) begin
                  state_nxt = ST_QUIESCE;
               end else if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_QUIESCE: begin
               if (wake) begin
                  state_nxt = ST_ON;
                  cnt_nxt   = '0;
               end else if (quiesce_ack_i[i]) begin
                  state_nxt = ST_OFF;
               end
            end
            ST_OFF: begin
               if (wake) begin
                  state_nxt = ST_ON;
                  cnt_nxt   = '0;
               end
            end
            default: begin
               state_nxt = ST_ON;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Output decode from the next state so en_o/quiesce_req_o come straight from flops
      always_comb begin
         en_nxt  = 1'b1;
         req_nxt = 1'b0;
         unique case (state_nxt)
            ST_QUIESCE: req_nxt = 1'b1;
            ST_OFF:     en_nxt  = 1'b0;
            default: begin
               en_nxt  = 1'b1;
               req_nxt = 1'b0;
            end
         endcase
      end

      assign en_o[i]          = en;
      assign quiesce_req_o[i] = req;

      if (BYPASS) begin : g_bypass
         assign clk_o[i] = clk_i;
      end else begin : g_gate
         logic en_lat;

         // Latch closed while clk_i is high so enable changes land on whole cycles
         always_latch begin
            if (!clk_i) en_lat <= en;
         end

         assign clk_o[i] = clk_i & en_lat;
      end
   end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomized bench for clock_gate_ctrl: gated and bypass builds side by side,
// both compared against an idle-run-length model of the gating rules.
module tb_clock_gate_ctrl;

   localparam int unsigned NCH    = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned NCYC   = 2400;
   localparam logic [NCH-1:0] ALL = '1;

   logic             clk = 1'b0;
   logic             rst;
   logic             test_en;
   logic [CNT_W-1:0] idle_cycles;
   logic [NCH-1:0]   allow_gate;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   ack;

   logic [NCH-1:0]   req_g, en_g, clk_g;
   logic [NCH-1:0]   req_b, en_b, clk_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: length of the current idle streak plus request/off flags
   int             run   [NCH];
   bit             req_m [NCH];
   bit             off_m [NCH];
   logic [NCH-1:0] en_exp;
   logic [NCH-1:0] req_exp;
   logic [NCH-1:0] prev_en;

   always #5 clk = ~clk;

   clock_gate_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .BYPASS(1'b0)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .test_en_i     (test_en),
      .idle_cycles_i (idle_cycles),
      .allow_gate_i  (allow_gate),
      .busy_i        (busy),
      .quiesce_ack_i (ack),
      .quiesce_req_o (req_g),
      .en_o          (en_g),
      .clk_o         (clk_g)
   );

   clock_gate_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .BYPASS(1'b1)) dut_byp (
      .clk_i         (clk),
      .rst_i         (rst),
      .test_en_i     (test_en),
      .idle_cycles_i (idle_cycles),
      .allow_gate_i  (allow_gate),
      .busy_i        (busy),
      .quiesce_ack_i (ack),
      .quiesce_req_o (req_b),
      .en_o          (en_b),
      .clk_o         (clk_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Apply one clock edge of the gating rules to the model
   task automatic model_edge();
      for (int i = 0; i < NCH; i++) begin
         bit wake;
         wake = busy[i] | ~allow_gate[i] | test_en;
         if (rst || wake) begin
            run[i]   = 0;
            req_m[i] = 1'b0;
            off_m[i] = 1'b0;
         end else if (off_m[i]) begin
            // stays off until woken
         end else if (req_m[i]) begin
            if (ack[i]) begin
               req_m[i] = 1'b0;
               off_m[i] = 1'b1;
            end
         end else if (run[i] >= int'(idle_cycles)) begin
            req_m[i] = 1'b1;
         end else begin
            run[i]++;
         end
         en_exp[i]  = ~off_m[i];
         req_exp[i] = req_m[i];
      end
   endtask

   task automatic drive(input int cyc);
      if (cyc < 20) begin
         rst = 1'b0; test_en = 1'b0; busy = '0; allow_gate = ALL;
         idle_cycles = CNT_W'(3);
         ack = (cyc >= 4) ? ALL : '0;
      end else if (cyc >= 2000 && cyc < 2300) begin
         rst = 1'b0; test_en = 1'b0; allow_gate = ALL; ack = '0;
         busy = (cyc == 2000) ? ALL : '0;
         idle_cycles = CNT_W'(255);
      end else begin
         rst     = ($urandom_range(0, 99) == 0);
         test_en = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < NCH; i++) begin
            busy[i]       = ($urandom_range(0, 7) == 0);
            allow_gate[i] = ($urandom_range(0, 15) != 0);
            ack[i]        = ($urandom_range(0, 2) == 0);
         end
         case ($urandom_range(0, 9))
            0:       idle_cycles = CNT_W'($urandom);
            1:       idle_cycles = '0;
            default: idle_cycles = CNT_W'($urandom_range(0, 4));
         endcase
      end
   endtask

   initial begin
      rst = 1'b1; test_en = 1'b0; busy = '0; ack = '0;
      allow_gate = ALL; idle_cycles = CNT_W'(3);
      en_exp = ALL; req_exp = '0;

      repeat (2) begin
         @(posedge clk);
         model_edge();
         #1;
         check("reset_en", 32'(en_g), 32'(ALL));
         check("reset_req", 32'(req_g), 32'(0));
         check("reset_en_byp", 32'(en_b), 32'(ALL));
      end
      prev_en = en_exp;
      @(negedge clk);
      drive(0);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         model_edge();
         #1;
         check("en", 32'(en_g), 32'(en_exp));
         check("req", 32'(req_g), 32'(req_exp));
         check("en_byp", 32'(en_b), 32'(en_exp));
         check("req_byp", 32'(req_b), 32'(req_exp));
         check("clk_hi_early", 32'(clk_g), 32'(prev_en));
         check("clk_byp_hi", 32'(clk_b), 32'(ALL));
         #3;
         check("clk_hi_late", 32'(clk_g), 32'(prev_en));
         prev_en = en_exp;
         @(negedge clk);
         #1;
         check("clk_lo", 32'(clk_g), 32'(0));
         check("clk_byp_lo", 32'(clk_b), 32'(0));
         drive(cyc + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Multi-channel clock-gating controller with idle hysteresis and a quiesce handshake.
- Each of NCH channels gates its own copy of the core clock.
- A channel gates only after its busy input has been low for a programmable number of consecutive cycles and the downstream logic has acknowledged a quiesce request.
- Any wake cause re-enables the channel within one cycle.
- Sits between the core clock root and per-unit clock domains (vector/scalar/LSU etc.); each channel drives one unit.

Parameters:
- NCH, 4: number of gated channels.
- CNT_W, 8: width of the idle counter and of `idle_cycles_i`.
- BYPASS, 0: when 1, `clk_o[i] = clk_i` unconditionally (FPGA build); state machines, `en_o` and the handshake still operate.

Ports:
- `clk_i`, input, 1: core clock, ungated.
- `rst_i`, input, 1: synchronous reset, active-high.
- `test_en_i`, input, 1: scan/test; 1 forces every channel on.
- `idle_cycles_i`, input, CNT_W: consecutive idle cycles required before quiesce; shared by all channels; sampled every cycle.
- `allow_gate_i`, input, NCH: per-channel software permission; 0 forces the channel on.
- `busy_i`, input, NCH: per-channel activity/wake; must originate in the ungated domain.
- `quiesce_ack_i`, input, NCH: downstream confirms it is safe to stop its clock.
- `quiesce_req_o`, output, NCH: registered request to the unit to quiesce.
- `en_o`, output, NCH: registered gate enable (1 = clock running).
- `clk_o`, output, NCH: gated clocks.

Behaviour:
- Wake cause for channel i, W = `busy_i[i] | ~allow_gate_i[i] | test_en_i`. Idle = ~W.
- Reset (`rst_i` = 1 at a rising edge), all channels:
  - state = ON, counter = 0, `en_o` = all 1s, `quiesce_req_o` = 0.
  - `clk_o` keeps toggling during reset so downstream logic sees the reset.
  - Reset mid-QUIESCE or in OFF returns the channel to ON at that edge.
- Per-channel FSM (registered, independent per channel):
  - ON: `en_o` = 1, req = 0.
    - Idle and `idle_cycles_i` == 0 -> QUIESCE.
    - Idle and `idle_cycles_i` != 0 -> COUNT, counter <= 1.
    - W -> stay in ON, counter <= 0.
  - COUNT: `en_o` = 1, req = 0.
    - W -> ON, counter <= 0.
    - Idle and counter >= `idle_cycles_i` -> QUIESCE.
    - Otherwise counter <= counter + 1, saturating at 2^CNT_W - 1 (no wrap).
    - If `idle_cycles_i` is lowered below the current count, the >= test moves to QUIESCE on the next idle cycle.
  - QUIESCE: `en_o` = 1, `quiesce_req_o` = 1.
    - W -> ON, req drops next cycle; W takes priority over a simultaneous ack.
    - Idle and `quiesce_ack_i` -> OFF.
    - Otherwise hold; there is no timeout.
  - OFF: `en_o` = 0, req = 0.
    - W -> ON, counter <= 0.
    - Ack is ignored in OFF, ON and COUNT.
- Threshold latency: with N = `idle_cycles_i` >= 1 and busy falling before edge E0, `quiesce_req_o` rises after edge E0+N (N+1 idle edges).
- Wake latency: W sampled high at edge E sets `en_o` = 1 after E. The first gated rising edge of `clk_o` is E+1.
- Gate element (BYPASS = 0):
  - A level latch, transparent while `clk_i` is low, captures `en_o`.
  - `clk_o[i] = clk_i & latched_en[i]`. This guarantees glitch-free output: no partial high pulses, enable changes visible only at whole-cycle boundaries.
  - The last clock edge delivered before gating is the edge at which the FSM enters OFF.
- BYPASS = 1: `clk_o = clk_i` replicated; everything else is unchanged.
- `test_en_i` = 1: every channel returns to or stays in ON at the next edge; `quiesce_req_o` = 0.

Test Plan:
- Reset then idle: `rst_i` for 2 cycles with `busy_i` = 0, `idle_cycles_i` = 3, `allow_gate_i` = all 1s.
  - Required: `en_o` = all 1s during reset; `quiesce_req_o` rises 4 edges after reset release.
  - Ack at the following edge -> `en_o` = 0 and `clk_o` flat from the next cycle.
- Hysteresis: `busy_i[0]` pulses 1 cycle when the count reaches 2 of 3.
  - Required: channel 0 returns to ON, counter restarts, req is delayed by a further 4 edges.
  - Other channels are unaffected.
- Wake from OFF: channel 1 OFF, `busy_i[1]` = 1 at edge E.
  - Required: `en_o[1]` = 1 after E; first `clk_o[1]` rising edge at E+1; no runt pulse (check pulse width equals the `clk_i` high time).
- Handshake abort: channel 2 in QUIESCE, `busy_i[2]` and `quiesce_ack_i[2]` both 1 at the same edge.
  - Required: ON, req low next cycle, `en_o[2]` stays 1.
- Overrides: `test_en_i` = 1 while channels are OFF -> all `en_o` = 1 next cycle.
  - `allow_gate_i[3]` = 0 -> channel 3 never leaves ON.
  - `idle_cycles_i` = 0 -> QUIESCE on the first idle edge; `idle_cycles_i` = 255 -> counter saturates without wrapping.
- BYPASS = 1 build: repeat scenario 1.
  - Required: `clk_o` always equals `clk_i`, while `en_o`/`quiesce_req_o` follow the same sequence as with BYPASS = 0.
